rptr_empty_ctrl: RTL and testbench

Parametrised read-domain pointer and empty-flag controller for the asynchronous FIFO. It is the next generation of the fixed 4-bit read pointer handler.
- Contains its own multi-stage synchroniser for the write-domain Gray pointer.
- Keeps binary and Gray read pointers of arbitrary depth.
- Produces registered empty, almost-empty, fill level, read-data-valid and sticky underflow status for the read-side consumer and the dual-port RAM read address.

---
 rtl/rptr_empty_ctrl.sv | 114 +++++++++++
 tb/tb_rptr_empty_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/rptr_empty_ctrl.sv
// Read-domain pointer and empty-flag controller for an asynchronous FIFO.
// Synchronises the write Gray pointer, advances the read pointer, and registers level/status flags.
module rptr_empty_ctrl #(
  parameter int ADDR_W      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int AE_THRESH   = 2
) (
  input  logic              i_rclk,
  input  logic              i_rst_n,
  input  logic              i_ren,
  input  logic [ADDR_W:0]   i_wptr_gray,
  input  logic              i_clr_underflow,
  output logic [ADDR_W-1:0] o_raddr,
  output logic [ADDR_W:0]   o_rptr_gray,
  output logic              o_empty,
  output logic              o_almost_empty,
  output logic [ADDR_W:0]   o_rd_level,
  output logic              o_rvalid,
  output logic              o_underflow
);

  localparam int PW = ADDR_W + 1;
  localparam logic [PW-1:0] AE_T = PW'(AE_THRESH);

  if (ADDR_W < 2 || ADDR_W > 10) begin : g_bad_addr_w
    $error("rptr_empty_ctrl: ADDR_W=%0d outside 2..10", ADDR_W);
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("rptr_empty_ctrl: SYNC_STAGES=%0d outside 2..4", SYNC_STAGES);
  end
  if (AE_THRESH < 0 || AE_THRESH > (2**ADDR_W) - 1) begin : g_bad_ae
    $error("rptr_empty_ctrl: AE_THRESH=%0d outside 0..2**ADDR_W-1", AE_THRESH);
  end

  logic [SYNC_STAGES-1:0][PW-1:0] wsync_reg;
  logic [PW-1:0] wsync;
  logic [PW-1:0] wbin;

  logic [PW-1:0] rbin_reg;
  logic [PW-1:0] rgray_reg;
  logic          empty_reg;
  logic          almost_empty_reg;
  logic [PW-1:0] level_reg;
  logic          rvalid_reg;
  logic          underflow_reg;

  logic          acc;
  logic [PW-1:0] rbin_next;
  logic [PW-1:0] rgray_next;
  logic [PW-1:0] level_next;
  logic          empty_next;
  logic          almost_empty_next;
  logic          underflow_next;

  // Write pointer crosses into the read domain here; stage 0 may go metastable.
  always_ff @(posedge i_rclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wsync_reg <= '0;
    end else begin
      wsync_reg[0] <= i_wptr_gray;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        wsync_reg[s] <= wsync_reg[s-1];
      end
    end
  end

  assign wsync = wsync_reg[SYNC_STAGES-1];

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  for (genvar gi = 0; gi < PW; gi++) begin : g_g2b
    assign wbin[gi] = ^wsync[PW-1:gi];
  end

  // Accept is gated by the registered flag only, so a stale empty can only block reads.
  assign acc        = i_ren & ~empty_reg;
  assign rbin_next  = rbin_reg + {{ADDR_W{1'b0}}, acc};
  assign rgray_next = rbin_next ^ (rbin_next >> 1);

  always_comb begin
    level_next        = wbin - rbin_next;
    empty_next        = (rgray_next == wsync);
    almost_empty_next = (level_next <= AE_T);
    underflow_next    = (i_ren & empty_reg) | (underflow_reg & ~i_clr_underflow);
  end

  always_ff @(posedge i_rclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rbin_reg         <= '0;
      rgray_reg        <= '0;
      empty_reg        <= 1'b1;
      almost_empty_reg <= 1'b1;
      level_reg        <= '0;
      rvalid_reg       <= 1'b0;
      underflow_reg    <= 1'b0;
    end else begin
      rbin_reg         <= rbin_next;
      rgray_reg        <= rgray_next;
      empty_reg        <= empty_next;
      almost_empty_reg <= almost_empty_next;
      level_reg        <= level_next;
      rvalid_reg       <= acc;
      underflow_reg    <= underflow_next;
    end
  end

  assign o_raddr        = rbin_reg[ADDR_W-1:0];
  assign o_rptr_gray    = rgray_reg;
  assign o_empty        = empty_reg;
  assign o_almost_empty = almost_empty_reg;
  assign o_rd_level     = level_reg;
  assign o_rvalid       = rvalid_reg;
  assign o_underflow    = underflow_reg;

endmodule

// File: tb/tb_rptr_empty_ctrl.sv
// Bench for rptr_empty_ctrl (ADDR_W=3): vector table, directed corner sequences,
// and random traffic against an occupancy-count reference model.
module tb_rptr_empty_ctrl;

  localparam int AW   = 3;
  localparam int SYNC = 2;
  localparam int AE   = 2;
  localparam int DEP  = 1 << AW;
  localparam int MODP = 2 * DEP;

  logic          i_rclk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_ren = 1'b0;
  logic [AW:0]   i_wptr_gray = '0;
  logic          i_clr_underflow = 1'b0;
  logic [AW-1:0] o_raddr;
  logic [AW:0]   o_rptr_gray;
  logic          o_empty;
  logic          o_almost_empty;
  logic [AW:0]   o_rd_level;
  logic          o_rvalid;
  logic          o_underflow;

  rptr_empty_ctrl #(.ADDR_W(AW), .SYNC_STAGES(SYNC), .AE_THRESH(AE)) dut (
    .i_rclk          (i_rclk),
    .i_rst_n         (i_rst_n),
    .i_ren           (i_ren),
    .i_wptr_gray     (i_wptr_gray),
    .i_clr_underflow (i_clr_underflow),
    .o_raddr         (o_raddr),
    .o_rptr_gray     (o_rptr_gray),
    .o_empty         (o_empty),
    .o_almost_empty  (o_almost_empty),
    .o_rd_level      (o_rd_level),
    .o_rvalid        (o_rvalid),
    .o_underflow     (o_underflow)
  );

  always #5 i_rclk = ~i_rclk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: absolute read count, history of write counts, status bits.
  int rcount;
  int wq[$];
  bit m_empty, m_uf, m_rv;
  int m_level;

  function automatic logic [AW:0] to_gray(input int v);
    logic [AW:0] b;
    b = (AW+1)'(v % MODP);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_init();
    rcount = 0; m_empty = 1; m_uf = 0; m_rv = 0; m_level = 0;
    wq.delete();
    for (int i = 0; i < SYNC; i++) wq.push_front(0);
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0; i_ren = 1'b0; i_wptr_gray = '0; i_clr_underflow = 1'b0;
    repeat (2) @(posedge i_rclk);
    @(negedge i_rclk);
    i_rst_n = 1'b1;
    model_init();
  endtask

  // One clock with write count wcnt presented; model steps from spec rules, all outputs compared.
  task automatic tick(input bit ren, input int wcnt, input bit clr);
    bit acc;
    int wseen;
    i_ren = ren; i_wptr_gray = to_gray(wcnt); i_clr_underflow = clr;
    @(posedge i_rclk);
    acc    = ren && !m_empty;
    m_uf   = (ren && m_empty) || (m_uf && !clr);
    m_rv   = acc;
    rcount = rcount + (acc ? 1 : 0);
    wq.push_front(wcnt);
    wseen  = wq[SYNC];
    while (wq.size() > SYNC + 1) void'(wq.pop_back());
    m_level = ((wseen - rcount) % MODP + MODP) % MODP;
    m_empty = (m_level == 0);
    #1;
    chk("empty", int'(o_empty), int'(m_empty));
    chk("almost_empty", int'(o_almost_empty), int'(m_level <= AE));
    chk("rd_level", int'(o_rd_level), m_level);
    chk("raddr", int'(o_raddr), rcount % DEP);
    chk("rptr_gray", int'(o_rptr_gray), int'(to_gray(rcount)));
    chk("rvalid", int'(o_rvalid), int'(m_rv));
    chk("underflow", int'(o_underflow), int'(m_uf));
    $display("cyc t=%0t ren=%0b wcnt=%0d clr=%0b -> lvl=%0d empty=%0b raddr=%0d rv=%0b uf=%0b",
             $time, ren, wcnt, clr, o_rd_level, o_empty, o_raddr, o_rvalid, o_underflow);
  endtask

  typedef struct {
    bit          ren;
    logic [AW:0] wg;
    bit          clr;
    bit          e;
    bit          ae;
    int          lvl;
    int          ra;
    bit          rv;
    bit          uf;
    logic [AW:0] rg;
  } vec_t;

  vec_t vt[7];
  int   rv_cnt;
  int   wcnt;

  initial begin
    // Underflow from reset, one entry arriving after 3 edges, last-entry read, set-beats-clear.
    vt[0] = '{1'b1, 4'b0000, 1'b0, 1'b1, 1'b1, 0, 0, 1'b0, 1'b1, 4'b0000};
    vt[1] = '{1'b0, 4'b0001, 1'b1, 1'b1, 1'b1, 0, 0, 1'b0, 1'b0, 4'b0000};
    vt[2] = '{1'b0, 4'b0001, 1'b0, 1'b1, 1'b1, 0, 0, 1'b0, 1'b0, 4'b0000};
    vt[3] = '{1'b0, 4'b0001, 1'b0, 1'b0, 1'b1, 1, 0, 1'b0, 1'b0, 4'b0000};
    vt[4] = '{1'b1, 4'b0001, 1'b0, 1'b1, 1'b1, 0, 1, 1'b1, 1'b0, 4'b0001};
    vt[5] = '{1'b1, 4'b0001, 1'b1, 1'b1, 1'b1, 0, 1, 1'b0, 1'b1, 4'b0001};
    vt[6] = '{1'b0, 4'b0001, 1'b1, 1'b1, 1'b1, 0, 1, 1'b0, 1'b0, 4'b0001};

    i_ren = 1'b1;
    repeat (2) @(posedge i_rclk);
    #1;
    chk("rst_empty", int'(o_empty), 1);
    chk("rst_almost_empty", int'(o_almost_empty), 1);
    chk("rst_level", int'(o_rd_level), 0);
    chk("rst_rptr_gray", int'(o_rptr_gray), 0);
    chk("rst_underflow", int'(o_underflow), 0);
    chk("rst_raddr", int'(o_raddr), 0);
    chk("rst_rvalid", int'(o_rvalid), 0);
    @(negedge i_rclk);
    i_rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      i_ren = vt[i].ren; i_wptr_gray = vt[i].wg; i_clr_underflow = vt[i].clr;
      @(posedge i_rclk);
      #1;
      chk($sformatf("vec%0d_empty", i), int'(o_empty), int'(vt[i].e));
      chk($sformatf("vec%0d_ae", i), int'(o_almost_empty), int'(vt[i].ae));
      chk($sformatf("vec%0d_level", i), int'(o_rd_level), vt[i].lvl);
      chk($sformatf("vec%0d_raddr", i), int'(o_raddr), vt[i].ra);
      chk($sformatf("vec%0d_rvalid", i), int'(o_rvalid), int'(vt[i].rv));
      chk($sformatf("vec%0d_uf", i), int'(o_underflow), int'(vt[i].uf));
      chk($sformatf("vec%0d_rgray", i), int'(o_rptr_gray), int'(vt[i].rg));
      $display("vec %0d: ren=%0b wg=%b clr=%0b -> empty=%0b lvl=%0d raddr=%0d rv=%0b uf=%0b",
               i, vt[i].ren, vt[i].wg, vt[i].clr, o_empty, o_rd_level, o_raddr, o_rvalid, o_underflow);
    end

    // Full FIFO (gray 1100) drained with i_ren held high.
    do_reset();
    chk("full_gray_in", int'(to_gray(8)), int'(4'b1100));
    repeat (3) tick(1'b0, 8, 1'b0);
    chk("full_level", int'(o_rd_level), 8);
    chk("full_not_empty", int'(o_empty), 0);
    rv_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 8, 1'b0);
      if (o_rvalid) rv_cnt++;
    end
    chk("full_rvalid_pulses", rv_cnt, 8);
    chk("full_raddr_wrap", int'(o_raddr), 0);
    chk("full_empty_after", int'(o_empty), 1);
    tick(1'b0, 8, 1'b1);

    // Pointer wrap: drive rbin to 14, then write count 17 leaves 3 entries.
    repeat (3) tick(1'b0, 14, 1'b0);
    repeat (6) tick(1'b1, 14, 1'b0);
    chk("wrap_pre_gray", int'(o_rptr_gray), int'(4'b1001));
    repeat (3) tick(1'b0, 17, 1'b0);
    chk("wrap_level", int'(o_rd_level), 3);
    tick(1'b1, 17, 1'b0);
    chk("wrap_gray15", int'(o_rptr_gray), int'(4'b1000));
    tick(1'b1, 17, 1'b0);
    chk("wrap_gray0", int'(o_rptr_gray), int'(4'b0000));
    tick(1'b1, 17, 1'b0);
    chk("wrap_gray1", int'(o_rptr_gray), int'(4'b0001));
    chk("wrap_empty", int'(o_empty), 1);

    // Asynchronous reset mid-burst, outputs checked before any clock edge.
    do_reset();
    repeat (3) tick(1'b0, 5, 1'b0);
    tick(1'b1, 5, 1'b0);
    @(negedge i_rclk);
    i_rst_n = 1'b0;
    #1;
    chk("arst_empty", int'(o_empty), 1);
    chk("arst_ae", int'(o_almost_empty), 1);
    chk("arst_level", int'(o_rd_level), 0);
    chk("arst_raddr", int'(o_raddr), 0);
    chk("arst_rgray", int'(o_rptr_gray), 0);
    chk("arst_rvalid", int'(o_rvalid), 0);
    chk("arst_uf", int'(o_underflow), 0);
    do_reset();
    repeat (4) tick(1'b0, 0, 1'b0);

    // Random traffic; the writer never exceeds DEP entries ahead of the reads.
    do_reset();
    wcnt = 0;
    for (int i = 0; i < 600; i++) begin
      if ((wcnt - rcount) < DEP && ($urandom_range(0, 99) < 45)) wcnt++;
      tick($urandom_range(0, 99) < 60, wcnt, $urandom_range(0, 9) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
